// File: rtl/sc_lifecounter_ctrl_pkg.sv
// Shared definitions for the Frogger lives sequencer: state encoding and
// parameter defaults, including the short hold-off used in simulation.
package sc_lifecounter_ctrl_pkg;

  localparam int unsigned DEF_MAX_LIVES      = 3;
  localparam int unsigned DEF_RESPAWN_CYCLES = 50_000_000;
  localparam int unsigned SIM_RESPAWN_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_HIT      = 3'd3,
    ST_EVAL     = 3'd4,
    ST_RESPAWN  = 3'd5,
    ST_GAMEOVER = 3'd6
  } state_t;

endpackage

// File: rtl/sc_lifecounter_ctrl_edge.sv
// Falling-edge detector: history bit resets to 1 so a level already low
// at reset release does not produce a pulse.
module sc_edge_falling (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 1'b1;
    else        hist <= din;
  end

  assign fall = hist & ~din;

endmodule

// File: rtl/sc_lifecounter_ctrl.sv
// Game-level sequencer driving the lives counter strobes, respawn hold-off
// and game-over. Optional freeze input enabled by SC_LIFECTRL_PAUSE_EN.
module sc_lifecounter_ctrl
  import sc_lifecounter_ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH      = 8,
  parameter int unsigned MAX_LIVES      = DEF_MAX_LIVES,
  parameter int unsigned RESPAWN_CYCLES = DEF_RESPAWN_CYCLES,
  parameter int unsigned TIMER_WIDTH    = 26
) (
  input  logic                 SC_LIFECTRL_CLOCK_50,
  input  logic                 SC_LIFECTRL_RESET_InLow,
  input  logic                 SC_LIFECTRL_start_InLow,
  input  logic                 SC_LIFECTRL_collision_InLow,
`ifdef SC_LIFECTRL_PAUSE_EN
  input  logic                 SC_LIFECTRL_pause_InLow,
`endif
  input  logic [DATAWIDTH-1:0] SC_LIFECTRL_count_InBUS,
  output logic                 SC_LIFECTRL_upcount_OutLow,
  output logic                 SC_LIFECTRL_clear_OutLow,
  output logic                 SC_LIFECTRL_respawn_OutLow,
  output logic                 SC_LIFECTRL_playing_OutHigh,
  output logic                 SC_LIFECTRL_gameover_OutHigh,
  output logic [DATAWIDTH-1:0] SC_LIFECTRL_lives_OutBUS
);

  localparam logic [DATAWIDTH-1:0]   MAX_L      = DATAWIDTH'(MAX_LIVES);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(RESPAWN_CYCLES - 1);

  state_t                 state, state_next;
  logic [TIMER_WIDTH-1:0] timer, timer_next;
  logic                   coll_fall;
  logic                   paused;
  logic                   spent;

`ifdef SC_LIFECTRL_PAUSE_EN
  assign paused = ~SC_LIFECTRL_pause_InLow;
`else
  assign paused = 1'b0;
`endif

  // History keeps tracking in every state, so a collision held low across
  // RESPAWN cannot re-trigger on return to PLAY.
  sc_edge_falling u_coll_edge (
    .clk   (SC_LIFECTRL_CLOCK_50),
    .rst_n (SC_LIFECTRL_RESET_InLow),
    .din   (SC_LIFECTRL_collision_InLow),
    .fall  (coll_fall)
  );

  assign spent = (SC_LIFECTRL_count_InBUS >= MAX_L);

  always_ff @(posedge SC_LIFECTRL_CLOCK_50 or negedge SC_LIFECTRL_RESET_InLow) begin
    if (!SC_LIFECTRL_RESET_InLow) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    case (state)
      ST_IDLE:     if (!SC_LIFECTRL_start_InLow) state_next = ST_CLEAR;
      ST_CLEAR:    state_next = ST_PLAY;
      ST_PLAY:     if (!paused && coll_fall) state_next = ST_HIT;
      ST_HIT:      state_next = ST_EVAL;
      ST_EVAL: begin
        if (spent) begin
          state_next = ST_GAMEOVER;
        end else begin
          timer_next = TIMER_LOAD;
          state_next = ST_RESPAWN;
        end
      end
      ST_RESPAWN: begin
        if (!paused) begin
          if (timer == '0) state_next = ST_PLAY;
          else             timer_next = timer - 1'b1;
        end
      end
      ST_GAMEOVER: if (!SC_LIFECTRL_start_InLow) state_next = ST_CLEAR;
      default:     state_next = ST_IDLE;
    endcase
  end

  assign SC_LIFECTRL_upcount_OutLow   = (state != ST_HIT);
  assign SC_LIFECTRL_clear_OutLow     = (state != ST_CLEAR);
  assign SC_LIFECTRL_respawn_OutLow   = (state != ST_RESPAWN);
  assign SC_LIFECTRL_playing_OutHigh  = (state == ST_PLAY) && !paused;
  assign SC_LIFECTRL_gameover_OutHigh = (state == ST_GAMEOVER);
  assign SC_LIFECTRL_lives_OutBUS     = spent ? '0 : (MAX_L - SC_LIFECTRL_count_InBUS);

endmodule

// File: tb/tb_sc_lifecounter_ctrl.sv
// Directed bench for sc_lifecounter_ctrl with a stand-in lives counter;
// MAX_LIVES=3, RESPAWN_CYCLES=4.
module tb_sc_lifecounter_ctrl;
  import sc_lifecounter_ctrl_pkg::*;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n, start_n, coll_n, pause_n;
  logic [DW-1:0] cnt, count_bus, force_val;
  logic          force_en;
  logic          upcount_n, clear_n, respawn_n, playing, gameover;
  logic [DW-1:0] lives;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned up_pulses = 0;
  int unsigned resp_lows = 0;
  int unsigned up0, r0;

  always #5 clk = ~clk;

  sc_lifecounter_ctrl #(
    .DATAWIDTH      (DW),
    .MAX_LIVES      (3),
    .RESPAWN_CYCLES (SIM_RESPAWN_CYCLES),
    .TIMER_WIDTH    (26)
  ) dut (
    .SC_LIFECTRL_CLOCK_50         (clk),
    .SC_LIFECTRL_RESET_InLow      (rst_n),
    .SC_LIFECTRL_start_InLow      (start_n),
    .SC_LIFECTRL_collision_InLow  (coll_n),
`ifdef SC_LIFECTRL_PAUSE_EN
    .SC_LIFECTRL_pause_InLow      (pause_n),
`endif
    .SC_LIFECTRL_count_InBUS      (count_bus),
    .SC_LIFECTRL_upcount_OutLow   (upcount_n),
    .SC_LIFECTRL_clear_OutLow     (clear_n),
    .SC_LIFECTRL_respawn_OutLow   (respawn_n),
    .SC_LIFECTRL_playing_OutHigh  (playing),
    .SC_LIFECTRL_gameover_OutHigh (gameover),
    .SC_LIFECTRL_lives_OutBUS     (lives)
  );

  // Stand-in lives counter with its active-high reset from the inverted rst_n.
  always_ff @(posedge clk or posedge (~rst_n)) begin
    if (~rst_n)          cnt <= '0;
    else if (!clear_n)   cnt <= '0;
    else if (!upcount_n) cnt <= cnt + 1'b1;
  end
  assign count_bus = force_en ? force_val : cnt;

  always @(negedge clk) begin
    if (rst_n && !upcount_n) up_pulses++;
    if (rst_n && !respawn_n) resp_lows++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle collision pulse issued from PLAY; returns at the EVAL cycle.
  task automatic hit_to_eval();
    coll_n = 1'b0;
    step(1);
    coll_n = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_n = 1'b1; coll_n = 1'b1; pause_n = 1'b1;
    force_en = 1'b0; force_val = '0;
    step(2);
    check("rst_upcount", upcount_n, 1);
    check("rst_clear", clear_n, 1);
    check("rst_respawn", respawn_n, 1);
    check("rst_playing", playing, 0);
    check("rst_gameover", gameover, 0);
    check("rst_lives", lives, 3);
    rst_n = 1'b1;
    step(2);
    check("idle_wait", playing, 0);

    // New game
    start_n = 1'b0;
    step(1);
    start_n = 1'b1;
    check("clear_pulse", clear_n, 0);
    check("clear_not_playing", playing, 0);
    step(1);
    check("clear_done", clear_n, 1);
    check("play_entry", playing, 1);
    check("play_lives", lives, 3);

    // Held collision: one hit, 4-cycle hold-off
    up0 = up_pulses; r0 = resp_lows;
    coll_n = 1'b0;
    step(1);
    check("hit_latency", upcount_n, 0);
    step(9);
    coll_n = 1'b1;
    step(2);
    #1;
    check("held_one_upcount", up_pulses - up0, 1);
    check("respawn_len", resp_lows - r0, 4);
    check("hit1_count", cnt, 1);
    check("hit1_lives", lives, 2);
    check("hit1_playing", playing, 1);

    // Second hit, then a collision edge inside RESPAWN
    up0 = up_pulses;
    hit_to_eval();
    check("eval_count", cnt, 2);
    check("eval_lives", lives, 1);
    step(1);
    check("respawn_entered", respawn_n, 0);
    coll_n = 1'b0;
    step(1);
    coll_n = 1'b1;
    step(6);
    #1;
    check("respawn_coll_ignored", up_pulses - up0, 1);
    check("hit2_count", cnt, 2);
    check("hit2_playing", playing, 1);

    // Third hit ends the game
    r0 = resp_lows;
    hit_to_eval();
    check("hit3_count", cnt, 3);
    check("hit3_lives", lives, 0);
    check("eval_not_over", gameover, 0);
    step(1);
    check("gameover", gameover, 1);
    check("gameover_not_playing", playing, 0);
    step(3);
    #1;
    check("gameover_no_respawn", resp_lows - r0, 0);
    check("gameover_hold", gameover, 1);

    // Start and collision together in GAMEOVER; start held into PLAY
    up0 = up_pulses;
    start_n = 1'b0; coll_n = 1'b0;
    step(1);
    coll_n = 1'b1;
    check("restart_clear", clear_n, 0);
    step(1);
    check("restart_count", cnt, 0);
    check("restart_lives", lives, 3);
    check("restart_playing", playing, 1);
    step(2);
    start_n = 1'b1;
    #1;
    check("start_ignored_play", playing, 1);
    check("start_ignored_clear", clear_n, 1);
    check("same_cycle_no_hit", up_pulses - up0, 0);

    // Reset in the second RESPAWN cycle
    hit_to_eval();
    step(2);
    check("pre_reset_respawn", respawn_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_respawn", respawn_n, 1);
    check("midrst_upcount", upcount_n, 1);
    check("midrst_playing", playing, 0);
    check("midrst_lives", lives, 3);
    step(2);
    rst_n = 1'b1;
    step(2);
    check("post_rst_idle", playing, 0);
    check("post_rst_clear", clear_n, 1);

    // Counter out of sync beyond MAX_LIVES
    start_n = 1'b0;
    step(1);
    start_n = 1'b1;
    step(1);
    force_en = 1'b1; force_val = 8'd7;
    #1;
    check("sat_lives", lives, 0);
    step(1);
    hit_to_eval();
    step(1);
    check("oos_gameover", gameover, 1);
    force_en = 1'b0;

`ifdef SC_LIFECTRL_PAUSE_EN
    start_n = 1'b0;
    step(1);
    start_n = 1'b1;
    step(1);
    r0 = resp_lows;
    hit_to_eval();
    step(2);
    pause_n = 1'b0;
    step(1);
    check("pause_playing_low", playing, 0);
    step(4);
    pause_n = 1'b1;
    step(8);
    #1;
    check("pause_respawn_len", resp_lows - r0, 9);
    check("pause_resume_play", playing, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sc_lifecounter_ctrl.md
Name: sc_lifecounter_ctrl

Overview:
- Game-level sequencer for the Frogger lives datapath.
- Turns raw collision and start events into the one-cycle active-low upcount and clear strobes consumed by the up-counting lives register, and reads that register's count back.
- Runs the respawn hold-off and raises game-over when the lives budget is spent.
- Sits between the collision detector / pushbutton block and the lives counter; its outputs also feed the display and frog-position logic.

Parameters:
- DATAWIDTH, 8: width of the lives-used count returned by the counter and of lives_remaining.
- MAX_LIVES, 3: number of hits that ends the game.
- RESPAWN_CYCLES, 50000000: hold-off length in clocks (1 s at 50 MHz); must be at least 1.
- TIMER_WIDTH, 26: width of the hold-off timer; must hold RESPAWN_CYCLES-1.

Ports:
- SC_LIFECTRL_CLOCK_50  in  1  system clock, 50 MHz.
- SC_LIFECTRL_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_LIFECTRL_start_InLow  in  1  start / new-game request, level, synchronous.
- SC_LIFECTRL_collision_InLow  in  1  frog-hit indication, level, may stay low many cycles.
- SC_LIFECTRL_count_InBUS  in  DATAWIDTH  lives-used value from the lives counter.
- SC_LIFECTRL_upcount_OutLow  out  1  one-cycle increment strobe to the counter.
- SC_LIFECTRL_clear_OutLow  out  1  one-cycle clear strobe to the counter.
- SC_LIFECTRL_respawn_OutLow  out  1  low for the whole respawn hold-off.
- SC_LIFECTRL_playing_OutHigh  out  1  high in PLAY only.
- SC_LIFECTRL_gameover_OutHigh  out  1  high in GAMEOVER.
- SC_LIFECTRL_lives_OutBUS  out  DATAWIDTH  lives remaining: MAX_LIVES minus count, saturating at 0.

Behaviour:
- Reset (async, low):
  - state=IDLE, timer=0, collision history register=1.
  - upcount, clear and respawn outputs =1; playing=0; gameover=0.
  - lives output is combinational from count_InBUS at all times.
- State encoding: IDLE, CLEAR, PLAY, HIT, EVAL, RESPAWN, GAMEOVER. Strobes are Moore outputs decoded from state, so they are glitch-free one-cycle lows.
- IDLE: start_InLow=0 -> CLEAR.
- CLEAR: clear_OutLow=0 for exactly 1 cycle -> PLAY.
- PLAY:
  - Falling edge of collision (history=1, current=0) -> HIT. A held-low collision yields exactly one hit.
  - start is ignored in PLAY.
- HIT: upcount_OutLow=0 for exactly 1 cycle -> EVAL. The counter registers the increment on the edge that leaves HIT.
- EVAL: one cycle; the updated count is visible here.
  - count >= MAX_LIVES -> GAMEOVER.
  - Otherwise load timer=RESPAWN_CYCLES-1 -> RESPAWN.
- RESPAWN:
  - respawn_OutLow=0; timer decrements each cycle.
  - timer==0 -> PLAY.
  - Collisions are ignored, but the edge history keeps tracking.
- GAMEOVER: gameover=1; start_InLow=0 -> CLEAR (new game, count returns to 0).
- Latency: collision edge to upcount low is 1 cycle. Hit to PLAY re-entry is 2+RESPAWN_CYCLES cycles.
- Boundary cases:
  - start and collision in the same cycle in IDLE/GAMEOVER: start wins, collision is ignored.
  - start held low through CLEAR into PLAY: no effect.
  - count already >= MAX_LIVES on entering EVAL (counter out of sync): still GAMEOVER.
  - lives_OutBUS=0 whenever count >= MAX_LIVES.
  - Reset mid-RESPAWN or mid-strobe: immediate return to the reset values; no partial strobe.
- The counter itself keeps its active-high reset; top level drives it from the inverted SC_LIFECTRL_RESET_InLow.

Optional Feature:
- Macro: SC_LIFECTRL_PAUSE_EN.
- Defined:
  - Adds input SC_LIFECTRL_pause_InLow. While it is low in PLAY or RESPAWN, the state and timer freeze and playing=0.
  - Collision edges that occur while paused are discarded; the history still updates.
- Undefined: no port, no freeze logic.

Decomposition:
- Shared package/include holds:
  - state localparams (3-bit encoding);
  - MAX_LIVES and RESPAWN_CYCLES defaults;
  - the simulation override RESPAWN_CYCLES=4.
- One sub-module, sc_edge_falling: registered history bit with async active-low reset to 1; outputs a one-cycle falling-edge pulse. Reusable for the start and pause inputs.

Test Plan (MAX_LIVES=3, RESPAWN_CYCLES=4):
- Reset low, then high; start low 1 cycle -> clear low 1 cycle, then playing=1, lives=3.
- Collision held low 10 cycles in PLAY -> exactly one upcount pulse, count=1, lives=2, respawn low exactly 4 cycles, then playing=1.
- Collision pulse during RESPAWN -> no upcount; count stays 1.
- Three separate collision edges -> after the third, EVAL then gameover=1, lives=0, no respawn; start low -> clear pulse, count=0, lives=3.
- Reset asserted in the 2nd RESPAWN cycle -> all outputs at reset values within the same cycle; IDLE after release.
- With SC_LIFECTRL_PAUSE_EN: pause low for 5 cycles mid-RESPAWN -> respawn-low duration becomes 9 cycles.
